// File: rtl/scratchmem_arb_pkg.sv
// Shared types and constants for the scratch-memory arbiter.
// Covers the state encoding, the Wishbone cycle-type codes and the bus widths.
package scratchmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int ADR_W = 14;
  localparam int DAT_W = 12;
  localparam int CTI_W = 3;

  // An acked classic or end-of-burst beat closes the access, so the slave needs a fresh cs edge.
  function automatic logic ends_access(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/scratchmem_arb_rr_pick.sv
// Combinational round-robin selector.
// It returns the first requester strictly after the last-granted index.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/scratchmem_arb.sv
// Round-robin arbiter sharing one 16K x 12 scratch memory among NREQ Wishbone masters.
// A grant is held for the master's whole cyc, with cs gaps and a stuck-slave timeout.
module scratchmem_arb
  import scratchmem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NREQ-1:0]         m_cyc_i,
  input  logic [NREQ-1:0]         m_stb_i,
  input  logic [NREQ-1:0]         m_we_i,
  input  logic [CTI_W*NREQ-1:0]   m_cti_i,
  input  logic [ADR_W*NREQ-1:0]   m_adr_i,
  input  logic [DAT_W*NREQ-1:0]   m_dat_i,
  output logic [NREQ-1:0]         m_ack_o,
  output logic [NREQ-1:0]         m_err_o,
  output logic [DAT_W-1:0]        m_dat_o,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    busy_o,
  output logic                    s_cs_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [CTI_W-1:0]        s_cti_o,
  output logic [ADR_W-1:0]        s_adr_o,
  output logic [DAT_W-1:0]        s_dat_o,
  input  logic                    s_ack_i,
  input  logic [DAT_W-1:0]        s_dat_i
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t            state, state_nx;
  logic [NREQ-1:0]   gnt_nx;
  logic [IDX_W-1:0]  ptr, ptr_nx;
  logic [CNT_W-1:0]  tcnt, tcnt_nx;
  logic [NREQ-1:0]   blocked, blocked_set;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;

  logic              g_cyc, g_stb, g_we;
  logic [CTI_W-1:0]  g_cti;
  logic [ADR_W-1:0]  g_adr;
  logic [DAT_W-1:0]  g_dat;
  logic              timeout_hit;

  assign req = m_cyc_i & m_stb_i & ~blocked;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  // ptr doubles as the granted index while a grant is held.
  assign g_cyc = m_cyc_i[ptr];
  assign g_stb = m_stb_i[ptr];
  assign g_we  = m_we_i[ptr];
  assign g_cti = m_cti_i[ptr*CTI_W +: CTI_W];
  assign g_adr = m_adr_i[ptr*ADR_W +: ADR_W];
  assign g_dat = m_dat_i[ptr*DAT_W +: DAT_W];

  assign timeout_hit = g_stb && !s_ack_i && (tcnt == CNT_W'(TIMEOUT - 1));

  assign m_dat_o = s_dat_i;
  assign m_ack_o = gnt_o & {NREQ{s_ack_i & ~rst_i}};
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt_o;
    ptr_nx      = ptr;
    tcnt_nx     = tcnt;
    blocked_set = '0;
    m_err_o     = '0;
    s_cs_o      = 1'b0;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_cti_o     = '0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_nx   = pick_oh;
          ptr_nx   = pick_idx;
          tcnt_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_cs_o  = g_cyc & g_stb;
        s_we_o  = g_we;
        s_cti_o = g_cti;
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        if (s_ack_i) begin
          tcnt_nx = '0;
        end else if (g_stb) begin
          tcnt_nx = tcnt + 1'b1;
        end
        if (!g_cyc) begin
          gnt_nx   = '0;
          state_nx = TURN;
        end else if (timeout_hit) begin
          m_err_o     = gnt_o & {NREQ{~rst_i}};
          blocked_set = gnt_o;
          gnt_nx      = '0;
          state_nx    = TURN;
        end else if (s_ack_i && ends_access(g_cti)) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (g_cyc) begin
          tcnt_nx  = '0;
          state_nx = GRANT;
        end else begin
          gnt_nx   = '0;
          state_nx = TURN;
        end
      end
      TURN: begin
        state_nx = IDLE;
      end
      default: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      gnt_o   <= '0;
      ptr     <= IDX_W'(NREQ - 1);
      tcnt    <= '0;
      blocked <= '0;
    end else begin
      state   <= state_nx;
      gnt_o   <= gnt_nx;
      ptr     <= ptr_nx;
      tcnt    <= tcnt_nx;
      blocked <= (blocked | blocked_set) & m_cyc_i;
    end
  end

endmodule
